// File: rtl/alu_mul_sequencer.sv
// Shift-add 32x32 -> low-32 multiplier controller that borrows the datapath ALU
// for every add and shift instead of owning private arithmetic.
module alu_mul_sequencer #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] mcand,
    input  logic [31:0] mplier,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    input  logic [31:0] alu_result,
    input  logic        alu_zero
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b1001;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ADD   = 3'd2,
        S_SHL   = 3'd3,
        S_SHR   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] acc_r;
    logic [31:0] mc_r;
    logic [31:0] mp_r;
    logic [5:0]  cnt_r;
    logic        busy_r;
    logic        done_r;
    logic        exit_s;

    // ALU drive is a pure function of the current state so the result is usable this cycle.
    always_comb begin
        alu_op  = OP_ADD;
        alu_op1 = 32'd0;
        alu_op2 = 32'd0;
        case (state_r)
            S_CHECK: begin
                alu_op  = OP_OR;
                alu_op1 = mp_r;
                alu_op2 = 32'd0;
            end
            S_ADD: begin
                alu_op  = OP_ADD;
                alu_op1 = acc_r;
                alu_op2 = mc_r;
            end
            S_SHL: begin
                alu_op  = OP_SLL;
                alu_op1 = mc_r;
                alu_op2 = 32'd1;
            end
            S_SHR: begin
                alu_op  = OP_SRL;
                alu_op1 = mp_r;
                alu_op2 = 32'd1;
            end
            default: begin
                alu_op  = OP_ADD;
                alu_op1 = 32'd0;
                alu_op2 = 32'd0;
            end
        endcase
    end

    // The counter limit wins over everything, so cnt can never pass 32.
    assign exit_s = (EARLY_EXIT && alu_zero) || (cnt_r == 6'd32);

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s = S_CHECK;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_CHECK: begin
                if (exit_s) begin
                    state_next_s = S_DONE;
                end else if (mp_r[0]) begin
                    state_next_s = S_ADD;
                end else begin
                    state_next_s = S_SHL;
                end
            end
            S_ADD:   state_next_s = S_SHL;
            S_SHL:   state_next_s = S_SHR;
            S_SHR:   state_next_s = S_CHECK;
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State, datapath registers and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            acc_r   <= 32'd0;
            mc_r    <= 32'd0;
            mp_r    <= 32'd0;
            cnt_r   <= 6'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != S_IDLE);
            done_r  <= (state_next_s == S_DONE);
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        acc_r <= 32'd0;
                        mc_r  <= mcand;
                        mp_r  <= mplier;
                        cnt_r <= 6'd0;
                    end
                end
                S_ADD: acc_r <= alu_result;
                S_SHL: mc_r  <= alu_result;
                S_SHR: begin
                    mp_r  <= alu_result;
                    cnt_r <= cnt_r + 6'd1;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = acc_r;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed and random bench for alu_mul_sequencer: one early-exit and one
// fixed-length instance, each wired to its own behavioural ALU.
module tb_alu_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic [31:0] mcand, mplier;

    logic        busy0, done0, zero0;
    logic [31:0] prod0, op1_0, op2_0, res0;
    logic [3:0]  op0;
    logic        busy1, done1, zero1;
    logic [31:0] prod1, op1_1, op2_1, res1;
    logic [3:0]  op1;

    int pass_cnt = 0;
    int total_cnt = 0;
    int x_errs = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    alu_mul_sequencer #(.EARLY_EXIT(1'b1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .mcand(mcand), .mplier(mplier),
        .busy(busy0), .done(done0), .product(prod0),
        .alu_op(op0), .alu_op1(op1_0), .alu_op2(op2_0),
        .alu_result(res0), .alu_zero(zero0)
    );

    alu_mul_sequencer #(.EARLY_EXIT(1'b0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mcand(mcand), .mplier(mplier),
        .busy(busy1), .done(done1), .product(prod1),
        .alu_op(op1), .alu_op1(op1_1), .alu_op2(op2_1),
        .alu_result(res1), .alu_zero(zero1)
    );

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b1000: return a >> b[4:0];
            4'b1001: return a << b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        res0  = alu_f(op0, op1_0, op2_0);
        zero0 = (res0 == 32'd0);
        res1  = alu_f(op1, op1_1, op2_1);
        zero1 = (res1 == 32'd0);
    end

    always @(negedge clk) begin
        if (armed && !rst && ($isunknown(op0) || $isunknown(op1))) x_errs++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int exp_latency(input logic [31:0] mp, input int sel);
        int k;
        int msb;
        if (sel == 1) begin
            k = 97;
            for (int i = 0; i < 32; i++) k += int'(mp[i]);
            return k;
        end
        if (mp == 32'd0) return 1;
        msb = 0;
        for (int i = 0; i < 32; i++) if (mp[i]) msb = i;
        k = 1;
        for (int i = 0; i <= msb; i++) k += 3 + int'(mp[i]);
        return k;
    endfunction

    function automatic logic sel_busy(input int sel);
        return (sel == 0) ? busy0 : busy1;
    endfunction
    function automatic logic sel_done(input int sel);
        return (sel == 0) ? done0 : done1;
    endfunction
    function automatic logic [31:0] sel_prod(input int sel);
        return (sel == 0) ? prod0 : prod1;
    endfunction

    // One multiply; poke_edge injects an ignored 9x9 start, rst_edge aborts the run.
    task automatic run_mul(input int sel, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_p, input int exp_k,
                           input int poke_edge, input int rst_edge, input string tag);
        int  k;
        int  busy_n;
        bit  seen;
        @(negedge clk);
        mcand = a;
        mplier = b;
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        mcand = ~a;
        mplier = ~b;
        check({tag, "_clr"}, sel_prod(sel), 32'd0);
        k = 0;
        seen = 1'b0;
        busy_n = int'(sel_busy(sel));
        while (!seen && k < 200) begin
            if (k + 1 == poke_edge) begin
                mcand = 32'd9;
                mplier = 32'd9;
                if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
            end
            if (k + 1 == rst_edge) rst = 1'b1;
            @(posedge clk); #1;
            k++;
            start0 = 1'b0;
            start1 = 1'b0;
            if (k == rst_edge) begin
                rst = 1'b0;
                check({tag, "_rst_busy"}, 32'(sel_busy(sel)), 32'd0);
                check({tag, "_rst_done"}, 32'(sel_done(sel)), 32'd0);
                check({tag, "_rst_prod"}, sel_prod(sel), 32'd0);
                return;
            end
            if (sel_done(sel)) seen = 1'b1;
            busy_n += int'(sel_busy(sel));
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(k), 32'(exp_k));
        check({tag, "_product"}, sel_prod(sel), exp_p);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_k + 1));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(sel_done(sel)), 32'd0);
        check({tag, "_idle"}, 32'(sel_busy(sel)), 32'd0);
        check({tag, "_hold"}, sel_prod(sel), exp_p);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          rsel;
        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        mcand = 32'd0;
        mplier = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_prod", prod0, 32'd0);
        check("rst_alu_op", 32'(op0), 32'd2);
        check("rst_alu_op1", op1_0, 32'd0);
        check("rst_alu_op2", op2_0, 32'd0);
        check("rst_busy_full", 32'(busy1), 32'd0);
        rst = 1'b0;
        armed = 1'b1;

        run_mul(0, 32'd5, 32'd0, 32'd0, 1, -1, -1, "t1_5x0");
        run_mul(0, 32'd3, 32'd7, 32'd21, 13, -1, -1, "t2_3x7");
        run_mul(0, 32'd6, 32'd9, 32'd54, 15, -1, -1, "t2_6x9");
        run_mul(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 129, -1, -1, "t3_max_early");
        run_mul(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 129, -1, -1, "t3_max_full");
        run_mul(1, 32'd3, 32'd7, 32'd21, 100, -1, -1, "t3_3x7_full");
        run_mul(0, 32'h00010000, 32'h00010000, 32'h00000000, 53, -1, -1, "t4_wrap");
        run_mul(0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 9, -1, -1, "t4_neg2x3");
        run_mul(0, 32'd3, 32'd7, 32'd21, 13, 4, -1, "t5_start_busy");
        run_mul(0, 32'd3, 32'd7, 32'd0, 13, -1, 6, "t6_rst_mid");
        @(posedge clk); #1;
        check("t6_no_done", 32'(done0), 32'd0);
        run_mul(0, 32'd3, 32'd7, 32'd21, 13, -1, -1, "t6_restart");

        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            rsel = (i % 4 == 0) ? 1 : 0;
            run_mul(rsel, ra, rb, ra * rb, exp_latency(rb, rsel), -1, -1, $sformatf("rnd%0d", i));
        end

        check("alu_op_never_x", 32'(x_errs), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
